pulse_emulator: RTL and testbench

PULSE_EMULATOR -- requirements
Module: pulse_emulator

---
 rtl/pulse_emulator.sv | 91 +++++++++
 tb/tb_pulse_emulator.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_emulator.sv
// Emulated detector pulse source: exponential decay v -= v>>DECAY_SHIFT on a
// fixed-point accumulator, with saturating pile-up and a baseline offset.
module pulse_emulator #(
  parameter int SIZE_ADC_DATA = 12,
  parameter int DECAY_SHIFT   = 4,
  parameter int FRAC          = 4,
  parameter int BASELINE      = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_valid,
  input  logic [SIZE_ADC_DATA-1:0] start_amp,
  output logic                     start_ready,
  output logic [SIZE_ADC_DATA-1:0] output_data,
  output logic                     busy,
  output logic                     pileup,
  output logic [15:0]              pulse_count
);

  localparam int W = SIZE_ADC_DATA + FRAC;
  localparam logic [W:0] V_MAX = {1'b0, {SIZE_ADC_DATA{1'b1}}, {FRAC{1'b0}}};
  localparam logic [31:0] OUT_MAX = 32'((1 << SIZE_ADC_DATA) - 1);
  localparam logic [SIZE_ADC_DATA-1:0] IDLE_OUT =
    (32'(BASELINE) > OUT_MAX) ? OUT_MAX[SIZE_ADC_DATA-1:0] : SIZE_ADC_DATA'(BASELINE);

  typedef enum logic {IDLE, DECAY} state_t;

  state_t                   state_q, state_d;
  logic [W-1:0]             v_q, v_d;
  logic [SIZE_ADC_DATA-1:0] out_q, out_d;
  logic                     pileup_q, pileup_d;
  logic [15:0]              count_q, count_d;

  logic         accept;
  logic [W-1:0] decayed;
  logic [W:0]   loaded;
  logic [31:0]  level;

  assign start_ready = reset;
  assign accept      = start_valid & start_ready;

  always_comb begin
    v_d      = v_q;
    pileup_d = 1'b0;
    count_d  = count_q;
    decayed  = v_q - (v_q >> DECAY_SHIFT);
    loaded   = {1'b0, decayed} + {1'b0, start_amp, {FRAC{1'b0}}};

    if (state_q == IDLE) begin
      v_d = accept ? {start_amp, {FRAC{1'b0}}} : '0;
    end else if (accept) begin
      v_d      = (loaded > V_MAX) ? V_MAX[W-1:0] : loaded[W-1:0];
      pileup_d = 1'b1;
    end else if (decayed[W-1:FRAC] == '0) begin
      // a pure-fraction residue would never reach zero on its own
      v_d = '0;
    end else begin
      v_d = decayed;
    end

    if (accept) begin
      count_d = count_q + 16'd1;
    end

    state_d = (v_d != '0) ? DECAY : IDLE;
    level   = 32'(BASELINE) + 32'(v_d[W-1:FRAC]);
    out_d   = (level > OUT_MAX) ? OUT_MAX[SIZE_ADC_DATA-1:0] : level[SIZE_ADC_DATA-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      v_q      <= '0;
      out_q    <= IDLE_OUT;
      pileup_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      out_q    <= out_d;
      pileup_q <= pileup_d;
      count_q  <= count_d;
    end
  end

  assign output_data = out_q;
  assign busy        = (state_q == DECAY);
  assign pileup      = pileup_q;
  assign pulse_count = count_q;

endmodule

// File: tb/tb_pulse_emulator.sv
// Bench for pulse_emulator: two instances (BASELINE 0 and 4000) driven in
// parallel and compared every step against an arithmetic pulse model.
module tb_pulse_emulator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_valid = 1'b0;
  logic [11:0] start_amp = '0;

  logic        ready_a, busy_a, pileup_a, ready_b, busy_b, pileup_b;
  logic [11:0] out_a, out_b;
  logic [15:0] count_a, count_b;

  int checks = 0;
  int failures = 0;

  // model state: mv is the pulse height scaled by 16
  int mv = 0;
  int mcount = 0;
  int mpile = 0;

  always #5 clk = ~clk;

  pulse_emulator dut_a (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_amp(start_amp),
    .start_ready(ready_a), .output_data(out_a), .busy(busy_a), .pileup(pileup_a),
    .pulse_count(count_a)
  );

  pulse_emulator #(.BASELINE(4000)) dut_b (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_amp(start_amp),
    .start_ready(ready_b), .output_data(out_b), .busy(busy_b), .pileup(pileup_b),
    .pulse_count(count_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_out(input int base);
    int l;
    l = base + mv / 16;
    return (l > 4095) ? 4095 : l;
  endfunction

  task automatic model_step();
    int nv;
    if (!reset) begin
      mv = 0; mcount = 0; mpile = 0;
    end else begin
      mpile = (start_valid && mv != 0) ? 1 : 0;
      if (start_valid) mcount = (mcount + 1) % 65536;
      if (mv == 0) begin
        mv = start_valid ? int'(start_amp) * 16 : 0;
      end else begin
        nv = mv - mv / 16;
        if (start_valid) begin
          nv = nv + int'(start_amp) * 16;
          if (nv > 4095 * 16) nv = 4095 * 16;
        end else if (nv / 16 == 0) begin
          nv = 0;
        end
        mv = nv;
      end
    end
  endtask

  task automatic apply_stimulus(input bit rst, input bit vld, input int amp);
    reset = rst;
    start_valid = vld;
    start_amp = 12'(amp);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_output(input string tag);
    check_eq({tag, "_out_a"}, out_a, exp_out(0));
    check_eq({tag, "_out_b"}, out_b, exp_out(4000));
    check_eq({tag, "_busy_a"}, busy_a, (mv != 0) ? 1 : 0);
    check_eq({tag, "_busy_b"}, busy_b, (mv != 0) ? 1 : 0);
    check_eq({tag, "_pile_a"}, pileup_a, mpile);
    check_eq({tag, "_pile_b"}, pileup_b, mpile);
    check_eq({tag, "_count_a"}, count_a, mcount);
    check_eq({tag, "_count_b"}, count_b, mcount);
    check_eq({tag, "_ready_a"}, ready_a, int'(reset));
    check_eq({tag, "_ready_b"}, ready_b, int'(reset));
  endtask

  initial begin
    // reset with a coincident request that must be ignored
    apply_stimulus(0, 1, 100);
    apply_stimulus(0, 1, 100);
    check_output("reset");
    check_eq("reset_out_a", out_a, 0);
    check_eq("reset_out_b", out_b, 4000);
    check_eq("reset_count", count_a, 0);

    // single pulse accepted on the first edge out of reset
    apply_stimulus(1, 1, 1600);
    check_output("single");
    check_eq("single_s0", out_a, 1600);
    check_eq("single_cnt", count_a, 1);
    apply_stimulus(1, 0, 0);
    check_eq("single_s1", out_a, 1500);
    apply_stimulus(1, 0, 0);
    check_eq("single_s2", out_a, 1406);

    // tail runs to exactly zero
    for (int i = 0; i < 400 && mv != 0; i++) begin
      apply_stimulus(1, 0, 0);
      check_output("tail");
    end
    check_eq("tail_busy", busy_a, 0);
    check_eq("tail_out", out_a, 0);
    check_eq("tail_base", out_b, 4000);

    // pile-up into saturation
    apply_stimulus(1, 1, 3000);
    check_output("pile0");
    apply_stimulus(1, 1, 4000);
    check_output("pile1");
    check_eq("pile_flag", pileup_a, 1);
    check_eq("pile_sat", out_a, 4095);
    apply_stimulus(1, 0, 0);
    check_eq("pile_clear", pileup_a, 0);
    check_eq("pile_decay", out_a, 3839);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, 0, 0);
      check_output("pile_tail");
    end

    // reset mid-pulse aborts and ignores a coincident request
    for (int i = 0; i < 400 && mv != 0; i++) apply_stimulus(1, 0, 0);
    apply_stimulus(1, 1, 1600);
    for (int i = 0; i < 100 && mv / 16 > 800; i++) begin
      apply_stimulus(1, 0, 0);
      check_output("mid");
    end
    apply_stimulus(0, 1, 1000);
    check_output("rst_mid");
    check_eq("rst_mid_out", out_a, 0);
    check_eq("rst_mid_busy", busy_a, 0);
    check_eq("rst_mid_cnt", count_a, 0);

    // baseline offset clamps high and returns to baseline
    apply_stimulus(1, 1, 500);
    check_output("base");
    check_eq("base_clamp", out_b, 4095);
    check_eq("base_plain", out_a, 500);
    for (int i = 0; i < 400 && mv != 0; i++) begin
      apply_stimulus(1, 0, 0);
      check_output("base_tail");
    end
    check_eq("base_return", out_b, 4000);

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) :
                                                   int'($urandom_range(0, 4095)));
      check_output("rand");
    end

    // counter wrap with zero-amplitude pulses
    apply_stimulus(0, 0, 0);
    for (int i = 0; i < 65536; i++) begin
      apply_stimulus(1, 1, 0);
      if (i % 8192 == 100) check_output("wrap_mid");
    end
    check_output("wrap");
    check_eq("wrap_count", count_a, 0);
    check_eq("wrap_idle", busy_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
